parity_rr_sched: RTL and testbench

//   Shares one parity-append stage between NREQ requesters. A round-robin

---
 rtl/parity_rr_sched.sv | 113 +++++++++++
 tb/tb_parity_rr_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rr_sched.sv
// parity_rr_sched
//   Shares one parity-append stage between NREQ byte requesters. A round-robin
//   arbiter grants one pending request per transfer. The granted byte is
//   registered together with its parity bit as {parity, byte}, and the word is
//   presented to the consumer through a valid/ready handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       req[i]=1: requester i has a byte pending
//   req_data  byte i at [i*DW +: DW]
//   gnt       one-hot grant; gnt[i]=1 means byte i is captured at this edge
//   o_valid   o_data/o_src hold a word
//   o_ready   consumer accepts the word when o_valid && o_ready
//   o_data    [DW] parity bit, [DW-1:0] captured byte
//   o_src     index of the requester that produced o_data
//   o_count   number of accepted words, wraps at 16 bits
module parity_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int ODD  = 0,
    localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [DW:0]          o_data,
    output logic [SW-1:0]        o_src,
    output logic [15:0]          o_count
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   ptr_q;
    logic [SW-1:0]   sel;
    logic [DW-1:0]   byte_sel;
    logic            can_load;
    logic            load;
    logic            accept;
    logic            found;
    int              idx;

    function automatic logic par_of(input logic [DW-1:0] b);
        return (ODD != 0) ? ~^b : ^b;
    endfunction

    assign o_valid  = (state_q == FULL);
    assign can_load = !o_valid || o_ready;
    assign accept   = o_valid && o_ready;

    // Round-robin search starts one past the last granted requester, so the
    // most recently served requester has the lowest priority next time.
    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        if (!rst && can_load) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(ptr_q) + k) % NREQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    sel      = SW'(idx);
                end
            end
        end
    end

    assign load     = found;
    assign byte_sel = req_data[int'(sel)*DW +: DW];

    // A load on an accepting edge keeps the stage FULL, sustaining one word
    // per cycle.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (accept) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SW'(NREQ - 1);
            o_data  <= '0;
            o_src   <= '0;
            o_count <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                o_data <= {par_of(byte_sel), byte_sel};
                o_src  <= sel;
                ptr_q  <= sel;
            end
            if (accept) begin
                o_count <= o_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_parity_rr_sched.sv
// tb_parity_rr_sched
//   Directed bench for parity_rr_sched (NREQ=4, DW=8). Two instances share
//   the stimulus: one even-parity, one odd-parity. A bench-side arbiter model
//   predicts grants; predicted words are queued at grant time and compared
//   when the consumer accepts them.
module tb_parity_rr_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic              o_ready;

    logic [NREQ-1:0]   gnt_e, gnt_o;
    logic              vld_e, vld_o;
    logic [DW:0]       dat_e, dat_o;
    logic [1:0]        src_e, src_o;
    logic [15:0]       cnt_e, cnt_o;

    parity_rr_sched #(.NREQ(NREQ), .DW(DW), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt_e),
        .o_valid(vld_e), .o_ready(o_ready), .o_data(dat_e), .o_src(src_e),
        .o_count(cnt_e)
    );

    parity_rr_sched #(.NREQ(NREQ), .DW(DW), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt_o),
        .o_valid(vld_o), .o_ready(o_ready), .o_data(dat_o), .o_src(src_o),
        .o_count(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW:0] d_even;
        logic [DW:0] d_odd;
        logic [1:0]  src;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  m_ptr;
    logic        m_valid;
    logic [15:0] m_count;
    logic [DW-1:0] bytes [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        bytes[i] = b;
        req_data[i*DW +: DW] = b;
    endtask

    // Inputs are driven after the falling edge; this task checks the grant,
    // updates the model for the coming rising edge, and checks registered
    // outputs at the next falling edge.
    task automatic cycle();
        logic [NREQ-1:0] g_exp;
        logic            can_load;
        logic            accept;
        int              id;
        exp_t            e;
        logic            par;
        #1;
        g_exp    = '0;
        can_load = !m_valid || o_ready;
        accept   = m_valid && o_ready && !rst;
        if (!rst && can_load) begin
            for (int k = 1; k <= NREQ; k++) begin
                id = (int'(m_ptr) + k) % NREQ;
                if (g_exp == '0 && req[id]) g_exp[id] = 1'b1;
            end
        end
        chk("gnt_even", 32'(gnt_e), 32'(g_exp));
        chk("gnt_odd", 32'(gnt_o), 32'(g_exp));
        if (m_valid && sb.size() > 0) begin
            chk("data_even", 32'(dat_e), 32'(sb[0].d_even));
            chk("data_odd", 32'(dat_o), 32'(sb[0].d_odd));
            chk("src", 32'(src_e), 32'(sb[0].src));
        end
        if (rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 2'(NREQ - 1);
            m_count = '0;
        end else begin
            if (accept) begin
                void'(sb.pop_front());
                m_count = m_count + 16'd1;
                m_valid = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g_exp[i]) begin
                    par      = ($countones(bytes[i]) % 2) == 1;
                    e.d_even = {par, bytes[i]};
                    e.d_odd  = {~par, bytes[i]};
                    e.src    = 2'(i);
                    sb.push_back(e);
                    m_ptr    = 2'(i);
                    m_valid  = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("o_valid", 32'(vld_e), 32'(m_valid));
        chk("o_count", 32'(cnt_e), 32'(m_count));
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        req      = '1;
        req_data = '0;
        o_ready  = 1'b1;
        m_ptr    = 2'(NREQ - 1);
        m_valid  = 1'b0;
        m_count  = '0;
        for (int i = 0; i < NREQ; i++) bytes[i] = '0;
        @(negedge clk);

        // Reset state, with requests pending to confirm grants are forced off
        cycle();
        cycle();
        chk("rst_o_data", 32'(dat_e), 32'h0);
        chk("rst_o_src", 32'(src_e), 32'h0);
        chk("rst_o_count", 32'(cnt_e), 32'h0);
        rst = 1'b0;
        req = '0;

        // Test 1: even parity of 8'b11101110 is 0
        set_byte(0, 8'b11101110);
        req = 4'b0001;
        cycle();
        chk("t1_data", 32'(dat_e), 32'h0EE);
        chk("t1_src", 32'(src_e), 32'h0);

        // Test 2: 8'b11111000 has five ones
        set_byte(0, 8'b11111000);
        cycle();
        chk("t2_even", 32'(dat_e), 32'h1F8);
        chk("t2_odd", 32'(dat_o), 32'h0F8);
        req = '0;
        cycle();
        cycle();

        // Test 3: all requesting from reset pointer -> 0,1,2,3,0,...
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_byte(i, 8'(8'h30 + i * 8'h11));
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            set_byte(i % NREQ, 8'($urandom_range(0, 255)));
            cycle();
            chk("t3_src_seq", 32'(src_e), 32'(i % NREQ));
        end
        req = '0;
        cycle();

        // Test 4: backpressure holds the word; release loads requester 1
        set_byte(0, 8'hA5);
        req = 4'b0001;
        cycle();
        o_ready = 1'b0;
        req = 4'b0110;
        set_byte(1, 8'h3C);
        set_byte(2, 8'h81);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_hold_data", 32'(dat_e), 32'h0A5);
        end
        o_ready = 1'b1;
        cycle();
        chk("t4_src_after", 32'(src_e), 32'h1);
        chk("t4_data_after", 32'(dat_e), 32'h03C);
        req = '0;
        cycle();

        // Test 5: o_count wrap
        req = 4'b0001;
        n = 0;
        while (m_count != 16'hFFFF && n < 70000) begin
            set_byte(0, 8'($urandom_range(0, 255)));
            cycle();
            n++;
        end
        chk("t5_at_max", 32'(cnt_e), 32'hFFFF);
        cycle();
        chk("t5_wrap", 32'(cnt_e), 32'h0);
        req = '0;
        cycle();

        // Test 6: reset while FULL, then requester 0 wins first
        o_ready = 1'b0;
        set_byte(3, 8'h5A);
        req = 4'b1000;
        cycle();
        rst = 1'b1;
        cycle();
        chk("t6_valid_rst", 32'(vld_e), 32'h0);
        rst = 1'b0;
        o_ready = 1'b1;
        set_byte(0, 8'h01);
        req = 4'b1001;
        cycle();
        chk("t6_first_src", 32'(src_e), 32'h0);
        chk("t6_first_data", 32'(dat_e), 32'h101);
        req = '0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
